// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice: MEM-stage FSM states and
// common field widths.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  typedef enum logic {
    MEM_IDLE,
    MEM_ACCESS
  } memState_t;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register bank. Each edge it either loads a new entry or
// inserts a bubble (valid and regWrite cleared; data fields hold).
// Optional macro MEM_ALIGN_CHECK_EN adds the registered misalign flag.
module mem_wb_register
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  loadEn,
  input  logic                  validIn,
  input  logic                  regWriteIn,
  input  logic                  memToRegIn,
  input  logic [DATA_W-1:0]     readDataIn,
  input  logic [WORD_W-1:0]     aluResultIn,
  input  logic [REG_ADDR_W-1:0] writeRegIn,
`ifdef MEM_ALIGN_CHECK_EN
  input  logic                  misalignIn,
  output logic                  misalign,
`endif
  output logic                  wbValid,
  output logic                  wbRegWrite,
  output logic                  wbMemToReg,
  output logic [DATA_W-1:0]     wbReadData,
  output logic [WORD_W-1:0]     wbALUResult,
  output logic [REG_ADDR_W-1:0] wbWriteReg
);

  // Load a new MEM/WB entry or insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbValid     <= 1'b0;
      wbRegWrite  <= 1'b0;
      wbMemToReg  <= 1'b0;
      wbReadData  <= '0;
      wbALUResult <= '0;
      wbWriteReg  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign    <= 1'b0;
`endif
    end else if (loadEn) begin
      wbValid     <= validIn;
      wbRegWrite  <= regWriteIn;
      wbMemToReg  <= memToRegIn;
      wbReadData  <= readDataIn;
      wbALUResult <= aluResultIn;
      wbWriteReg  <= writeRegIn;
`ifdef MEM_ALIGN_CHECK_EN
      misalign    <= misalignIn;
`endif
    end else begin
      wbValid     <= 1'b0;
      wbRegWrite  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign    <= 1'b0;
`endif
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores over a req/ack handshake, stalls the front
// of the pipeline while an access is outstanding, resolves PCSrc and feeds
// the MEM/WB register. Optional macro MEM_ALIGN_CHECK_EN rejects word
// accesses with ALUResultIn[1:0] != 0 and reports them on misalign.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hitIn,
  input  logic [WORD_W-1:0]     branchTargetIn,
  input  logic                  zeroFlagIn,
  input  logic [WORD_W-1:0]     ALUResultIn,
  input  logic [DATA_W-1:0]     readData2In,
  input  logic [REG_ADDR_W-1:0] writeRegIn,
  input  logic                  MemReadIn,
  input  logic                  MemWriteIn,
  input  logic                  BranchIn,
  input  logic                  RegWriteIn,
  input  logic                  MemToRegIn,
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_W-1:0]     memAddr,
  output logic [DATA_W-1:0]     memWData,
  input  logic [DATA_W-1:0]     memRData,
  input  logic                  memAck,
  output logic                  stall,
  output logic                  PCSrc,
  output logic [WORD_W-1:0]     branchTargetOut,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                  misalign,
`endif
  output logic                  wbValid,
  output logic                  wbRegWrite,
  output logic                  wbMemToReg,
  output logic [DATA_W-1:0]     wbReadData,
  output logic [WORD_W-1:0]     wbALUResult,
  output logic [REG_ADDR_W-1:0] wbWriteReg
);

  memState_t         state;
  logic              memOp;
  logic              misaligned;
  logic              issueOp;
  logic              wbLoad;
  logic              wbValidNext;
  logic              wbRegWriteNext;
  logic [DATA_W-1:0] wbReadDataNext;

  assign memOp = hitIn & (MemReadIn | MemWriteIn);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = memOp & (ALUResultIn[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign issueOp = memOp & ~misaligned;

  assign PCSrc           = hitIn & BranchIn & zeroFlagIn;
  assign branchTargetOut = branchTargetIn;

  // Stall and MEM/WB next-entry selection for the current state.
  always_comb begin
    stall          = 1'b0;
    wbLoad         = 1'b0;
    wbValidNext    = hitIn;
    wbRegWriteNext = hitIn & RegWriteIn & ~misaligned;
    wbReadDataNext = '0;
    case (state)
      MEM_IDLE: begin
        stall  = issueOp;
        wbLoad = ~issueOp;
      end
      MEM_ACCESS: begin
        stall  = ~memAck;
        wbLoad = memAck;
        if (!memWe) wbReadDataNext = memRData;
      end
      default: begin
        stall  = 1'b0;
        wbLoad = 1'b0;
      end
    endcase
  end

  // Request FSM: latch the access in IDLE, hold it until memAck.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MEM_IDLE;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (issueOp) begin
            state    <= MEM_ACCESS;
            memReq   <= 1'b1;
            memWe    <= MemWriteIn;
            memAddr  <= ALUResultIn[ADDR_W-1:0];
            memWData <= readData2In;
          end
        end
        MEM_ACCESS: begin
          if (memAck) begin
            state  <= MEM_IDLE;
            memReq <= 1'b0;
          end
        end
        default: begin
          state  <= MEM_IDLE;
          memReq <= 1'b0;
        end
      endcase
    end
  end

  mem_wb_register #(
    .DATA_W (DATA_W)
  ) uWb (
    .clk         (clk),
    .rst_n       (rst_n),
    .loadEn      (wbLoad),
    .validIn     (wbValidNext),
    .regWriteIn  (wbRegWriteNext),
    .memToRegIn  (MemToRegIn),
    .readDataIn  (wbReadDataNext),
    .aluResultIn (ALUResultIn),
    .writeRegIn  (writeRegIn),
`ifdef MEM_ALIGN_CHECK_EN
    .misalignIn  (misaligned),
    .misalign    (misalign),
`endif
    .wbValid     (wbValid),
    .wbRegWrite  (wbRegWrite),
    .wbMemToReg  (wbMemToReg),
    .wbReadData  (wbReadData),
    .wbALUResult (wbALUResult),
    .wbWriteReg  (wbWriteReg)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage. Expected values come from a
// transaction-level view: each memory op is described by its address, data
// and ack latency, and the bench derives the cycle-by-cycle outputs.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        hitIn;
  logic [31:0] branchTargetIn;
  logic        zeroFlagIn;
  logic [31:0] ALUResultIn;
  logic [31:0] readData2In;
  logic [4:0]  writeRegIn;
  logic        MemReadIn, MemWriteIn, BranchIn, RegWriteIn, MemToRegIn;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWData, memRData;
  logic        memAck;
  logic        stall, PCSrc;
  logic [31:0] branchTargetOut;
  logic        wbValid, wbRegWrite, wbMemToReg;
  logic [31:0] wbReadData, wbALUResult;
  logic [4:0]  wbWriteReg;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int errors = 0;
  int checks = 0;

  mem_access_stage #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hitIn           (hitIn),
    .branchTargetIn  (branchTargetIn),
    .zeroFlagIn      (zeroFlagIn),
    .ALUResultIn     (ALUResultIn),
    .readData2In     (readData2In),
    .writeRegIn      (writeRegIn),
    .MemReadIn       (MemReadIn),
    .MemWriteIn      (MemWriteIn),
    .BranchIn        (BranchIn),
    .RegWriteIn      (RegWriteIn),
    .MemToRegIn      (MemToRegIn),
    .memReq          (memReq),
    .memWe           (memWe),
    .memAddr         (memAddr),
    .memWData        (memWData),
    .memRData        (memRData),
    .memAck          (memAck),
    .stall           (stall),
    .PCSrc           (PCSrc),
    .branchTargetOut (branchTargetOut),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign        (misalign),
`endif
    .wbValid         (wbValid),
    .wbRegWrite      (wbRegWrite),
    .wbMemToReg      (wbMemToReg),
    .wbReadData      (wbReadData),
    .wbALUResult     (wbALUResult),
    .wbWriteReg      (wbWriteReg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Non-memory instruction (ALU, branch, or a bubble carrying mem bits).
  task automatic doAlu(input logic hit, input logic [31:0] alu, input logic [4:0] wreg,
                       input logic rw, input logic mtr, input logic br, input logic zero,
                       input logic [31:0] target, input logic rdBubble);
    hitIn = hit; MemReadIn = rdBubble & ~hit; MemWriteIn = 1'b0;
    BranchIn = br; zeroFlagIn = zero; branchTargetIn = target;
    ALUResultIn = alu; writeRegIn = wreg; RegWriteIn = rw; MemToRegIn = mtr;
    readData2In = $urandom; memAck = 1'b0; memRData = $urandom;
    #1;
    check("alu.stall", 32'(stall), 32'd0);
    check("alu.memReq", 32'(memReq), 32'd0);
    check("alu.PCSrc", 32'(PCSrc), 32'(hit & br & zero));
    check("alu.target", branchTargetOut, target);
    @(posedge clk); #1;
    check("alu.wbValid", 32'(wbValid), 32'(hit));
    check("alu.wbRegWrite", 32'(wbRegWrite), 32'(hit & rw));
    check("alu.wbMemToReg", 32'(wbMemToReg), 32'(mtr));
    check("alu.wbALUResult", wbALUResult, alu);
    check("alu.wbWriteReg", 32'(wbWriteReg), 32'(wreg));
    check("alu.wbReadData", wbReadData, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    check("alu.misalign", 32'(misalign), 32'd0);
`endif
  endtask

  // Load or store acknowledged after 'waits' extra cycles in ACCESS.
  task automatic doMem(input bit isLoad, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int unsigned waits, input logic [4:0] wreg);
    hitIn = 1'b1; MemReadIn = isLoad; MemWriteIn = !isLoad;
    BranchIn = 1'b0; zeroFlagIn = 1'($urandom); branchTargetIn = $urandom;
    ALUResultIn = addr; readData2In = wdata; writeRegIn = wreg;
    RegWriteIn = isLoad; MemToRegIn = isLoad; memAck = 1'b0; memRData = $urandom;
    #1;
    check("mem.issueStall", 32'(stall), 32'd1);
    check("mem.issueNoReq", 32'(memReq), 32'd0);
    check("mem.PCSrc", 32'(PCSrc), 32'd0);
    @(posedge clk); #1;
    check("mem.req", 32'(memReq), 32'd1);
    check("mem.addr", memAddr, addr);
    check("mem.we", 32'(memWe), 32'(!isLoad));
    if (!isLoad) check("mem.wdata", memWData, wdata);
    check("mem.bubbleValid", 32'(wbValid), 32'd0);
    check("mem.bubbleRegWrite", 32'(wbRegWrite), 32'd0);
    for (int unsigned i = 0; i < waits; i++) begin
      memRData = $urandom;
      #1;
      check("mem.waitStall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      check("mem.waitReq", 32'(memReq), 32'd1);
      check("mem.waitAddr", memAddr, addr);
      check("mem.waitValid", 32'(wbValid), 32'd0);
    end
    memAck = 1'b1; memRData = rdata;
    #1;
    check("mem.ackStall", 32'(stall), 32'd0);
    check("mem.ackReq", 32'(memReq), 32'd1);
    @(posedge clk); #1;
    memAck = 1'b0;
    check("mem.doneReq", 32'(memReq), 32'd0);
    check("mem.wbValid", 32'(wbValid), 32'd1);
    check("mem.wbRegWrite", 32'(wbRegWrite), 32'(isLoad));
    check("mem.wbMemToReg", 32'(wbMemToReg), 32'(isLoad));
    check("mem.wbReadData", wbReadData, isLoad ? rdata : 32'd0);
    check("mem.wbALUResult", wbALUResult, addr);
    check("mem.wbWriteReg", 32'(wbWriteReg), 32'(wreg));
  endtask

  initial begin
    logic [31:0] a, d, r;
    logic [4:0]  w;
    int unsigned kind;

    // Reset held with a load presented at the EX/MEM inputs.
    rst_n = 1'b0; hitIn = 1'b1; MemReadIn = 1'b1; MemWriteIn = 1'b0;
    BranchIn = 1'b0; zeroFlagIn = 1'b0; branchTargetIn = '0;
    ALUResultIn = 32'h40; readData2In = '0; writeRegIn = 5'd7;
    RegWriteIn = 1'b1; MemToRegIn = 1'b1; memAck = 1'b0; memRData = '0;
    #3;
    check("rst.memReq", 32'(memReq), 32'd0);
    check("rst.wbValid", 32'(wbValid), 32'd0);
    check("rst.wbRegWrite", 32'(wbRegWrite), 32'd0);
    check("rst.memAddr", memAddr, 32'd0);
    check("rst.stall", 32'(stall), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("rst.heldReq", 32'(memReq), 32'd0);
    rst_n = 1'b1;
    doMem(1'b1, 32'h40, 32'd0, 32'h12345678, 0, 5'd7);

    // Directed cases.
    doAlu(1'b1, 32'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    doMem(1'b1, 32'h10, 32'd0, 32'hDEADBEEF, 3, 5'd2);
    doMem(1'b0, 32'h20, 32'd3, $urandom, 0, 5'd0);
    doAlu(1'b1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd1, 1'b0);
    doAlu(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd1, 1'b0);
    doAlu(1'b0, 32'h44, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);

    // Reset asserted during the second ACCESS cycle.
    hitIn = 1'b1; MemReadIn = 1'b1; MemWriteIn = 1'b0; BranchIn = 1'b0;
    ALUResultIn = 32'h80; writeRegIn = 5'd9; RegWriteIn = 1'b1; MemToRegIn = 1'b1;
    memAck = 1'b0;
    @(posedge clk); #1;
    check("rstmid.req1", 32'(memReq), 32'd1);
    @(posedge clk); #1;
    check("rstmid.req2", 32'(memReq), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid.asyncDrop", 32'(memReq), 32'd0);
    #2;
    rst_n = 1'b1;
    hitIn = 1'b0; MemReadIn = 1'b0; memAck = 1'b1; memRData = 32'hCAFEF00D;
    #1;
    check("rstmid.lateAckStall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    memAck = 1'b0;
    check("rstmid.lateAckReq", 32'(memReq), 32'd0);
    check("rstmid.lateAckValid", 32'(wbValid), 32'd0);
    check("rstmid.lateAckData", wbReadData, 32'd0);
    doMem(1'b1, 32'h84, 32'd0, 32'h0BADCAFE, 1, 5'd4);

`ifdef MEM_ALIGN_CHECK_EN
    hitIn = 1'b1; MemReadIn = 1'b1; MemWriteIn = 1'b0; ALUResultIn = 32'h13;
    writeRegIn = 5'd6; RegWriteIn = 1'b1; MemToRegIn = 1'b1;
    #1;
    check("mis.stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check("mis.noReq", 32'(memReq), 32'd0);
    check("mis.flag", 32'(misalign), 32'd1);
    check("mis.wbRegWrite", 32'(wbRegWrite), 32'd0);
    doAlu(1'b1, 32'd7, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
`endif

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      a = $urandom; d = $urandom; r = $urandom; w = 5'($urandom);
`ifdef MEM_ALIGN_CHECK_EN
      a[1:0] = 2'b00;
`endif
      case (kind)
        0: doMem(1'b1, a, d, r, $urandom_range(0, 4), w);
        1: doMem(1'b0, a, d, r, $urandom_range(0, 4), w);
        2: doAlu(1'($urandom), a, w, 1'($urandom), 1'($urandom), 1'b1, 1'($urandom), d, 1'($urandom));
        default: doAlu(1'($urandom), a, w, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom), d, 1'($urandom));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
